// File: rtl/hex_sr_ctrl.sv
// hex_sr_ctrl -- random-access sequencer for a 6-bit-wide recirculating
// shift register of LENGTH entries (six lanes sharing one shift/recirc
// control).
//
// Tracks the logical index of the entry at the register output (head).
// Accepts one read/write request at a time. Rotates the register until
// head matches the requested address. Then it either samples the word in
// place (read) or replaces it with a single non-recirculating shift (write).
//
// Optional feature macro: HEX_SR_CTRL_IDLE_SPIN_EN
//   defined   : the register rotates continuously while idle with no request
//   undefined : the register holds still while idle
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid/req_ready     : request handshake
//   req_write               : 1 = write, 0 = read
//   req_addr                : logical entry index
//   req_wdata               : write data
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata               : read data (0 for writes and errors)
//   rsp_err                 : address out of range
//   sr_shift                : shift enable for the register
//   sr_recirc               : 1 = output word re-enters, 0 = sr_data_in enters
//   sr_data_in              : word shifted in when sr_recirc = 0
//   sr_data_out             : word currently at the register output
module hex_sr_ctrl #(
  parameter int LENGTH = 200,
  parameter int ADDR_W = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [5:0]        req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [5:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              sr_shift,
  output logic              sr_recirc,
  output logic [5:0]        sr_data_in,
  input  logic [5:0]        sr_data_out
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LENGTH - 1);
  localparam logic [ADDR_W:0]   LEN_EXT = (ADDR_W + 1)'(LENGTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEK,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_head;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [5:0]          r_wdata;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [5:0]          r_rdata;
  logic                r_err;

  logic                w_hit;
  logic                w_addr_bad;
  logic [ADDR_W-1:0]   w_head_inc;
  logic                w_sr_shift;
  logic                w_sr_recirc;
  logic [5:0]          w_sr_din;

  assign w_hit      = (r_head == r_addr);
  assign w_addr_bad = ({1'b0, req_addr} >= LEN_EXT);
  // Wrap at LENGTH, not at 2^ADDR_W.
  assign w_head_inc = (r_head == LAST) ? '0 : r_head + 1'b1;

  // The shift controls decode directly from the registered state. This way
  // the shift happens on the very edge where the decision is made, and head
  // advances in lock-step with the register.
  always_comb begin
    w_sr_shift  = 1'b0;
    w_sr_recirc = 1'b1;
    w_sr_din    = '0;
    case (r_state)
      S_SEEK: begin
        if (!w_hit) begin
          w_sr_shift = 1'b1;
        end else if (r_write) begin
          w_sr_shift  = 1'b1;
          w_sr_recirc = 1'b0;
          w_sr_din    = r_wdata;
        end
      end
      S_IDLE: begin
`ifdef HEX_SR_CTRL_IDLE_SPIN_EN
        // Rotate only on edges that do not accept a request. Then the
        // seek distance is measured from the head value at the accept edge.
        if (!rst && !req_valid) begin
          w_sr_shift = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_head      <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_sr_shift) begin
        r_head <= w_head_inc;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_write     <= req_write;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (w_addr_bad) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_err       <= 1'b1;
              r_rdata     <= '0;
            end else begin
              r_state <= S_SEEK;
            end
          end
        end
        S_SEEK: begin
          if (w_hit) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_err       <= 1'b0;
            r_rdata     <= r_write ? 6'd0 : sr_data_out;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_rdata     <= '0;
            r_err       <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign sr_shift   = w_sr_shift;
  assign sr_recirc  = w_sr_recirc;
  assign sr_data_in = w_sr_din;

endmodule

// File: tb/tb_hex_sr_ctrl.sv
module tb_hex_sr_ctrl;

  localparam int L  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [5:0]    req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [5:0]    rsp_rdata;
  logic          rsp_err;
  logic          sr_shift;
  logic          sr_recirc;
  logic [5:0]    sr_data_in;
  logic [5:0]    sr_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_sr_ctrl #(.LENGTH(L), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .sr_shift(sr_shift), .sr_recirc(sr_recirc), .sr_data_in(sr_data_in),
    .sr_data_out(sr_data_out)
  );

  // Recirculating shift register model (physical view, unaffected by rst).
  logic [5:0] phys [L] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17};
  int p = 0;

  assign sr_data_out = phys[p];

  always @(posedge clk) begin
    if (sr_shift) begin
      phys[p] <= sr_recirc ? phys[p] : sr_data_in;
      p       <= (p + 1) % L;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    check({tag, "_rsp_err"},   32'(rsp_err), 0);
    check({tag, "_sr_shift"},  32'(sr_shift), 0);
    check({tag, "_sr_recirc"}, 32'(sr_recirc), 1);
    check({tag, "_sr_din"},    32'(sr_data_in), 0);
    check({tag, "_head"},      32'(dut.r_head), 0);
  endtask

  // Call just after an edge (or at a negedge) with the DUT idle. Returns
  // just after the response handshake edge.
  task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [5:0] wd,
                        input int hold,
                        output logic [5:0] rd, output logic er, output int rsh,
                        output int wsh, output int lat, output logic [5:0] wseen);
    bit got;
    rsh = 0; wsh = 0; lat = 0; wseen = '0; got = 0; rd = '0; er = 1'b0;
    check("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    while (lat < 40) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (sr_shift) begin
        if (sr_recirc) rsh++;
        else begin
          wsh++;
          wseen = sr_data_in;
        end
      end
      @(posedge clk);
      lat++;
    end
    if (!got) begin
      check("rsp_timeout", 0, 1);
    end else begin
      rd = rsp_rdata;
      er = rsp_err;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_rsp_valid", 32'(rsp_valid), 1);
        check("hold_req_ready", 32'(req_ready), 0);
        check("hold_rdata",     32'(rsp_rdata), 32'(rd));
        check("hold_err",       32'(rsp_err), 32'(er));
        check("hold_no_shift",  32'(sr_shift), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [5:0]    wd;
    logic [5:0]    rd;
    logic          er;
    int            rsh;
    int            wsh;
    int            lat;
    logic [AW-1:0] hd;
  } vec_t;

  vec_t       tbl [20];
  logic [5:0] rd, wseen, exp_d;
  logic       er;
  int         rsh, wsh, lat;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           wr    addr   wdata  rdata  err   rsh wsh lat head
    tbl[0]  = '{1'b1, 4'd5, 6'h2A, 6'h00, 1'b0, 5, 1, 6, 4'd6};
    tbl[1]  = '{1'b0, 4'd5, 6'h00, 6'h2A, 1'b0, 7, 0, 8, 4'd5};
    tbl[2]  = '{1'b0, 4'd5, 6'h00, 6'h2A, 1'b0, 0, 0, 1, 4'd5};
    tbl[3]  = '{1'b1, 4'd0, 6'h01, 6'h00, 1'b0, 3, 1, 4, 4'd1};
    tbl[4]  = '{1'b1, 4'd1, 6'h02, 6'h00, 1'b0, 0, 1, 1, 4'd2};
    tbl[5]  = '{1'b1, 4'd2, 6'h03, 6'h00, 1'b0, 0, 1, 1, 4'd3};
    tbl[6]  = '{1'b1, 4'd3, 6'h04, 6'h00, 1'b0, 0, 1, 1, 4'd4};
    tbl[7]  = '{1'b1, 4'd4, 6'h05, 6'h00, 1'b0, 0, 1, 1, 4'd5};
    tbl[8]  = '{1'b1, 4'd5, 6'h06, 6'h00, 1'b0, 0, 1, 1, 4'd6};
    tbl[9]  = '{1'b1, 4'd6, 6'h07, 6'h00, 1'b0, 0, 1, 1, 4'd7};
    tbl[10] = '{1'b1, 4'd7, 6'h08, 6'h00, 1'b0, 0, 1, 1, 4'd0};
    tbl[11] = '{1'b0, 4'd7, 6'h00, 6'h08, 1'b0, 7, 0, 8, 4'd7};
    tbl[12] = '{1'b0, 4'd0, 6'h00, 6'h01, 1'b0, 1, 0, 2, 4'd0};
    tbl[13] = '{1'b0, 4'd3, 6'h00, 6'h04, 1'b0, 3, 0, 4, 4'd3};
    tbl[14] = '{1'b0, 4'd9, 6'h00, 6'h00, 1'b1, 0, 0, 0, 4'd3};
    tbl[15] = '{1'b0, 4'd1, 6'h00, 6'h02, 1'b0, 6, 0, 7, 4'd1};
    tbl[16] = '{1'b0, 4'd2, 6'h00, 6'h03, 1'b0, 1, 0, 2, 4'd2};
    tbl[17] = '{1'b0, 4'd4, 6'h00, 6'h05, 1'b0, 2, 0, 3, 4'd4};
    tbl[18] = '{1'b0, 4'd5, 6'h00, 6'h06, 1'b0, 1, 0, 2, 4'd5};
    tbl[19] = '{1'b0, 4'd6, 6'h00, 6'h07, 1'b0, 1, 0, 2, 4'd6};

    #2 rst = 1'b1;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

`ifndef HEX_SR_CTRL_IDLE_SPIN_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_shift",  32'(sr_shift), 0);
      check("idle_recirc", 32'(sr_recirc), 1);
      check("idle_din",    32'(sr_data_in), 0);
    end
    check("idle_head", 32'(dut.r_head), 0);

    foreach (tbl[i]) begin
      do_req(tbl[i].wr, tbl[i].a, tbl[i].wd, 0, rd, er, rsh, wsh, lat, wseen);
      check($sformatf("v%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
      check($sformatf("v%0d_err", i),   32'(er), 32'(tbl[i].er));
      check($sformatf("v%0d_rsh", i),   32'(rsh), 32'(tbl[i].rsh));
      check($sformatf("v%0d_wsh", i),   32'(wsh), 32'(tbl[i].wsh));
      check($sformatf("v%0d_lat", i),   32'(lat), 32'(tbl[i].lat));
      check($sformatf("v%0d_head", i),  32'(dut.r_head), 32'(tbl[i].hd));
      if (tbl[i].wr) check($sformatf("v%0d_wdata", i), 32'(wseen), 32'(tbl[i].wd));
    end

    // Out-of-range request with the host stalling the response.
    do_req(1'b0, 4'd10, 6'h00, 4, rd, er, rsh, wsh, lat, wseen);
    check("oor_err",   32'(er), 1);
    check("oor_rdata", 32'(rd), 0);
    check("oor_shift", 32'(rsh + wsh), 0);
    check("oor_head",  32'(dut.r_head), 6);

    // Reset in the middle of a seek.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst2_head", 32'(dut.r_head), 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd7;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '0;
    repeat (3) @(posedge clk);
    #1 check("midseek_head", 32'(dut.r_head), 3);
    check("midseek_shift", 32'(sr_shift), 1);
    #2 rst = 1'b1;
    #1 check_reset_vals("midseek_rst");
    @(negedge clk); rst = 1'b0;
    exp_d = phys[p];
    do_req(1'b0, 4'd0, 6'h00, 0, rd, er, rsh, wsh, lat, wseen);
    check("post_rst_rdata", 32'(rd), 32'(exp_d));
    check("post_rst_rsh",   32'(rsh), 0);
    check("post_rst_lat",   32'(lat), 1);
    check("post_rst_err",   32'(er), 0);
`else
    // Idle spin: 10 idle edges from reset move head to 10 mod 8 = 2.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("spin_head", 32'(dut.r_head), 2);
    check("spin_shift", 32'(sr_shift), 1);
    exp_d = phys[(p + 7) % L];
    do_req(1'b0, 4'd1, 6'h00, 0, rd, er, rsh, wsh, lat, wseen);
    check("spin_rdata", 32'(rd), 32'(exp_d));
    check("spin_rsh",   32'(rsh), 7);
    check("spin_lat",   32'(lat), 8);
    check("spin_err",   32'(er), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
